// File: rtl/ts_pkg.sv
// Shared TS arbitration constants and the arbiter state encoding.
package ts_pkg;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int unsigned TS_PKT_LEN   = 188;
  localparam int unsigned NUM_CH       = 4;

  typedef enum logic {IDLE, FWD} state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way rotating-priority pick: first request at or after i_ptr wins.
module rr_arbiter4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic       o_grant_valid,
  output logic [1:0] o_grant_idx
);
  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = i_ptr;
    w_found       = 1'b0;
    w_idx         = i_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = i_ptr + i[1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found     = 1'b1;
        o_grant_idx = w_idx;
      end
    end
  end
endmodule

// File: rtl/ts_packet_arbiter.sv
// Packet-granular round-robin arbiter merging four sync-recovered TS channels
// into one stream; losing packet starts are counted per channel.
module ts_packet_arbiter
  import ts_pkg::*;
#(
  parameter int unsigned PKT_LEN     = TS_PKT_LEN,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           ch_en,
  input  logic [3:0]           sync_in,
  input  logic [3:0]           valid_in,
  input  logic [31:0]          byte_in,
  output logic [7:0]           byte_out,
  output logic                 valid_out,
  output logic                 sync_out,
  output logic [1:0]           ch_sel,
  output logic                 busy,
  output logic                 trunc_err,
  output logic                 timeout_err,
  output logic [4*CNT_W-1:0]   drop_cnt
);
  localparam int unsigned IDLE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             r_state, w_state_nx;
  logic [1:0]         r_rr_ptr, w_rr_ptr_nx;
  logic [7:0]         r_byte_cnt, w_byte_cnt_nx;
  logic [IDLE_W-1:0]  r_idle_cnt, w_idle_cnt_nx;
  logic [7:0]         r_byte_out, w_byte_out_nx;
  logic               r_valid_out, w_valid_out_nx;
  logic               r_sync_out, w_sync_out_nx;
  logic [1:0]         r_ch_sel, w_ch_sel_nx;
  logic               r_trunc_err, w_trunc_err_nx;
  logic               r_timeout_err, w_timeout_err_nx;
  logic [CNT_W-1:0]   r_drop_cnt [NUM_CH];
  logic [3:0]         w_drop_inc;

  logic [3:0]         w_req;
  logic               w_grant_valid;
  logic [1:0]         w_grant_idx;
  logic               w_g_valid;
  logic               w_g_sync;
  logic [7:0]         w_g_byte;
  logic [7:0]         w_win_byte;

  assign w_req      = sync_in & valid_in & ch_en;
  assign w_g_valid  = valid_in[r_ch_sel];
  assign w_g_sync   = sync_in[r_ch_sel];
  assign w_g_byte   = byte_in[{r_ch_sel, 3'b000} +: 8];
  assign w_win_byte = byte_in[{w_grant_idx, 3'b000} +: 8];

  rr_arbiter4 u_rr (
    .i_req         (w_req),
    .i_ptr         (r_rr_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_nx       = r_state;
    w_rr_ptr_nx      = r_rr_ptr;
    w_byte_cnt_nx    = r_byte_cnt;
    w_idle_cnt_nx    = r_idle_cnt;
    w_byte_out_nx    = r_byte_out;
    w_valid_out_nx   = 1'b0;
    w_sync_out_nx    = 1'b0;
    w_ch_sel_nx      = r_ch_sel;
    w_trunc_err_nx   = 1'b0;
    w_timeout_err_nx = 1'b0;
    w_drop_inc       = '0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_byte_out_nx  = w_win_byte;
          w_valid_out_nx = 1'b1;
          w_sync_out_nx  = 1'b1;
          w_ch_sel_nx    = w_grant_idx;
          w_byte_cnt_nx  = 8'd1;
          w_idle_cnt_nx  = '0;
          w_state_nx     = FWD;
          w_drop_inc     = w_req & ~(4'd1 << w_grant_idx);
        end
      end
      FWD: begin
        // Every other requester loses, including on the last-byte cycle.
        w_drop_inc = w_req & ~(4'd1 << r_ch_sel);
        if (w_g_valid) begin
          w_byte_out_nx  = w_g_byte;
          w_valid_out_nx = 1'b1;
          w_idle_cnt_nx  = '0;
          if (w_g_sync) begin
            w_sync_out_nx  = 1'b1;
            w_trunc_err_nx = 1'b1;
            w_byte_cnt_nx  = 8'd1;
          end else begin
            w_byte_cnt_nx = r_byte_cnt + 8'd1;
            if (r_byte_cnt == 8'(PKT_LEN - 1)) begin
              w_state_nx  = IDLE;
              w_rr_ptr_nx = r_ch_sel + 2'd1;
            end
          end
        end else if (r_idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
          w_timeout_err_nx = 1'b1;
          w_idle_cnt_nx    = '0;
          w_state_nx       = IDLE;
          w_rr_ptr_nx      = r_ch_sel + 2'd1;
        end else begin
          w_idle_cnt_nx = r_idle_cnt + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_byte_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_byte_out    <= '0;
      r_valid_out   <= 1'b0;
      r_sync_out    <= 1'b0;
      r_ch_sel      <= '0;
      r_trunc_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_rr_ptr      <= w_rr_ptr_nx;
      r_byte_cnt    <= w_byte_cnt_nx;
      r_idle_cnt    <= w_idle_cnt_nx;
      r_byte_out    <= w_byte_out_nx;
      r_valid_out   <= w_valid_out_nx;
      r_sync_out    <= w_sync_out_nx;
      r_ch_sel      <= w_ch_sel_nx;
      r_trunc_err   <= w_trunc_err_nx;
      r_timeout_err <= w_timeout_err_nx;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        r_drop_cnt[i] <= '0;
      end else if (w_drop_inc[i] && (r_drop_cnt[i] != '1)) begin
        r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      drop_cnt[CNT_W*i +: CNT_W] = r_drop_cnt[i];
    end
  end

  assign byte_out    = r_byte_out;
  assign valid_out   = r_valid_out;
  assign sync_out    = r_sync_out;
  assign ch_sel      = r_ch_sel;
  assign busy        = (r_state == FWD);
  assign trunc_err   = r_trunc_err;
  assign timeout_err = r_timeout_err;
endmodule
